// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between writeback and a buffered multiply/divide result queue.
// Optional RFARB_SCOREBOARD_EN adds q_reg/q_hit to expose pending buffered writes to hazard logic.
module regfile_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  input  logic        md_exc,
  output logic        md_ready,
  output logic        pipe_stall,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
`ifdef RFARB_SCOREBOARD_EN
  ,
  input  logic [4:0]  q_reg,
  output logic        q_hit
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  logic [4:0]       ent_reg      [DEPTH];
  logic [31:0]      ent_data     [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic [4:0]       ent_reg_nxt  [DEPTH];
  logic [31:0]      ent_data_nxt [DEPTH];
  logic [DEPTH-1:0] ent_valid_nxt;
  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]    starve_cnt, starve_nxt;

  logic [AW-1:0] rd_idx, wr_idx;
  logic          buf_empty, buf_full, head_live;
  logic [4:0]    md_eff_reg;
  logic          wb_eff;
  logic          grant_force, grant_wb, grant_head, grant_byp;
  logic          pop, enq;

  assign rd_idx     = rd_ptr[AW-1:0];
  assign wr_idx     = wr_ptr[AW-1:0];
  assign buf_empty  = (wr_ptr == rd_ptr);
  assign buf_full   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head_live  = !buf_empty && ent_valid[rd_idx];
  assign md_eff_reg = md_exc ? 5'd30 : md_reg;
  assign wb_eff     = wb_we && (wb_reg != 5'd0);

  // Fixed-priority grant decode: force > writeback > head drain > bypass.
  always_comb begin
    grant_force = (starve_cnt == STARVE_MAX) && head_live;
    grant_wb    = !grant_force && wb_eff;
    grant_head  = !grant_force && !wb_eff && !buf_empty;
    grant_byp   = !grant_force && !wb_eff && buf_empty && md_valid;
    pop         = grant_force || grant_head;
    enq         = md_valid && (!buf_full || pop) && !grant_byp && (md_eff_reg != 5'd0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
      ent_valid  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg[i]  <= 5'd0;
        ent_data[i] <= 32'd0;
      end
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      starve_cnt <= starve_nxt;
      ent_valid  <= ent_valid_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg[i]  <= ent_reg_nxt[i];
        ent_data[i] <= ent_data_nxt[i];
      end
    end
  end

  // Kill is applied before the enqueue so a same-cycle md arrival survives.
  always_comb begin
    ent_valid_nxt = ent_valid;
    for (int i = 0; i < DEPTH; i++) begin
      ent_reg_nxt[i]  = ent_reg[i];
      ent_data_nxt[i] = ent_data[i];
    end
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    starve_nxt = starve_cnt;

    if (grant_wb) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_reg[i] == wb_reg) ent_valid_nxt[i] = 1'b0;
      end
    end
    if (pop) begin
      ent_valid_nxt[rd_idx] = 1'b0;
      rd_ptr_nxt            = rd_ptr + 1'b1;
    end
    if (enq) begin
      ent_valid_nxt[wr_idx] = 1'b1;
      ent_reg_nxt[wr_idx]   = md_eff_reg;
      ent_data_nxt[wr_idx]  = md_data;
      wr_ptr_nxt            = wr_ptr + 1'b1;
    end

    if (pop || buf_empty) begin
      starve_nxt = '0;
    end else if (grant_wb && head_live && (starve_cnt != STARVE_MAX)) begin
      starve_nxt = starve_cnt + 1'b1;
    end
  end

  always_comb begin
    md_ready         = 1'b0;
    pipe_stall       = 1'b0;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'd0;
    if (reset_n) begin
      md_ready   = !buf_full || pop;
      pipe_stall = grant_force;
      if (pop && ent_valid[rd_idx]) begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = ent_reg[rd_idx];
        data_writeReg    = ent_data[rd_idx];
      end else if (grant_wb) begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = wb_reg;
        data_writeReg    = wb_data;
      end else if (grant_byp && (md_eff_reg != 5'd0)) begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = md_eff_reg;
        data_writeReg    = md_data;
      end
    end
  end

`ifdef RFARB_SCOREBOARD_EN
  always_comb begin
    q_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_reg[i] == q_reg) && (q_reg != 5'd0)) q_hit = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed plus random bench for regfile_write_arbiter against a queue-based reference model.
module tb_regfile_write_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wb_we, md_valid, md_exc;
  logic [4:0]  wb_reg, md_reg;
  logic [31:0] wb_data, md_data;
  logic        md_ready, pipe_stall, ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset_n(reset_n),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_exc(md_exc),
    .md_ready(md_ready), .pipe_stall(pipe_stall),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    bit          v;
  } ent_t;

  ent_t        q[$];
  int          starve;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] dut_rf [32];
  logic        last_we, last_ready, last_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_we",    {31'd0, ctrl_writeEnable}, 32'd0);
    chk("rst_ready", {31'd0, md_ready},         32'd0);
    chk("rst_stall", {31'd0, pipe_stall},       32'd0);
    chk("rst_reg",   {27'd0, ctrl_writeReg},    32'd0);
    chk("rst_data",  data_writeReg,             32'd0);
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_reg = 0; wb_data = 0;
    md_valid = 0; md_reg = 0; md_data = 0; md_exc = 0;
  endtask

  // One cycle: model predicts this cycle's port write, compares, then advances to next negedge.
  task automatic step();
    bit          hv, full_start, popped, byp, e_we, e_stall, e_ready;
    logic [4:0]  e_reg, mreg;
    logic [31:0] e_data;
    ent_t        h;
    #1;
    mreg       = md_exc ? 5'd30 : md_reg;
    hv         = (q.size() > 0) && q[0].v;
    full_start = (q.size() == DEPTH);
    popped = 0; byp = 0; e_we = 0; e_stall = 0; e_reg = 0; e_data = 0;
    if (starve == LIMIT && hv) begin
      h = q.pop_front();
      popped = 1; e_stall = 1; e_we = 1; e_reg = h.r; e_data = h.d; starve = 0;
    end else if (wb_we && wb_reg != 0) begin
      e_we = 1; e_reg = wb_reg; e_data = wb_data;
      if (hv && starve < LIMIT) starve++;
      foreach (q[i]) if (q[i].r == wb_reg) q[i].v = 0;
    end else if (q.size() > 0) begin
      h = q.pop_front();
      popped = 1; starve = 0;
      if (h.v) begin e_we = 1; e_reg = h.r; e_data = h.d; end
    end else if (md_valid) begin
      byp = 1;
      if (mreg != 0) begin e_we = 1; e_reg = mreg; e_data = md_data; end
    end
    e_ready = !full_start || popped;

    chk("we",    {31'd0, ctrl_writeEnable}, {31'd0, e_we});
    chk("ready", {31'd0, md_ready},         {31'd0, e_ready});
    chk("stall", {31'd0, pipe_stall},       {31'd0, e_stall});
    if (e_we) begin
      chk("wreg",  {27'd0, ctrl_writeReg}, {27'd0, e_reg});
      chk("wdata", data_writeReg,          e_data);
    end
    last_we = ctrl_writeEnable; last_ready = md_ready; last_stall = pipe_stall;
    if (ctrl_writeEnable === 1'b1) dut_rf[ctrl_writeReg] = data_writeReg;

    if (md_valid && e_ready && !byp && mreg != 0) q.push_back('{mreg, md_data, 1'b1});
    if (q.size() == 0) starve = 0;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int stall_at;
    int stall_cnt;
    for (int i = 0; i < 32; i++) dut_rf[i] = 32'd0;
    starve = 0;
    reset_n = 0;
    idle_inputs();
    md_valid = 1; md_reg = 5'd9; md_data = 32'h55; wb_we = 1; wb_reg = 5'd3;
    repeat (2) @(negedge clock);
    #1 chk_reset_outputs();
    idle_inputs();
    reset_n = 1;

    // 1: idle bypass
    md_valid = 1; md_reg = 5'd5; md_data = 32'd7;
    step();
    idle_inputs();
    step();
    chk("t1_rf5", dut_rf[5], 32'd7);
    chk("t1_idle_we", {31'd0, last_we}, 32'd0);

    // 2: writeback busy while md arrives
    wb_we = 1; wb_reg = 5'd3; wb_data = 32'h33;
    md_valid = 1; md_reg = 5'd4; md_data = 32'd9;
    step();
    md_valid = 0;
    step();
    step();
    wb_we = 0;
    step();
    chk("t2_rf4", dut_rf[4], 32'd9);
    chk("t2_rf3", dut_rf[3], 32'h33);

    // 3: kill of a stale buffered result
    wb_we = 1; wb_reg = 5'd1; wb_data = 32'h11;
    md_valid = 1; md_reg = 5'd6; md_data = 32'h66;
    step();
    md_valid = 0; wb_reg = 5'd6; wb_data = 32'd1;
    step();
    idle_inputs();
    step();
    chk("t3_killed_pop_we", {31'd0, last_we}, 32'd0);
    chk("t3_rf6", dut_rf[6], 32'd1);

    // 4: full buffer back-pressure
    wb_we = 1; wb_reg = 5'd2; wb_data = 32'h22;
    md_valid = 1; md_reg = 5'd10; md_data = 32'hA0; step();
    md_reg = 5'd11; md_data = 32'hB0; step();
    md_reg = 5'd12; md_data = 32'hC0; step();
    chk("t4_full_ready", {31'd0, last_ready}, 32'd0);
    step();
    chk("t4_full_ready2", {31'd0, last_ready}, 32'd0);
    wb_we = 0;
    step();
    chk("t4_pop_ready", {31'd0, last_ready}, 32'd1);
    idle_inputs();
    repeat (3) step();
    chk("t4_rf12", dut_rf[12], 32'hC0);
    chk("t4_rf11", dut_rf[11], 32'hB0);

    // 5: starvation force
    wb_we = 1; wb_reg = 5'd9; wb_data = 32'h99;
    md_valid = 1; md_reg = 5'd8; md_data = 32'h88;
    stall_at = -1; stall_cnt = 0;
    for (int c = 0; c < 9; c++) begin
      step();
      md_valid = 0;
      if (last_stall) begin
        stall_cnt++;
        if (stall_at < 0) stall_at = c;
      end
    end
    chk("t5_stall_cycle", stall_at, 32'd5);
    chk("t5_stall_count", stall_cnt, 32'd1);
    chk("t5_rf8", dut_rf[8], 32'h88);
    idle_inputs();
    step();

    // 6: exception target, then reset with buffered entries
    md_valid = 1; md_exc = 1; md_reg = 5'd7; md_data = 32'd2;
    step();
    chk("t6_rf30", dut_rf[30], 32'd2);
    idle_inputs();
    wb_we = 1; wb_reg = 5'd2; wb_data = 32'h2;
    md_valid = 1; md_reg = 5'd13; md_data = 32'hD0; step();
    md_reg = 5'd14; md_data = 32'hE0; step();
    idle_inputs();
    reset_n = 0;
    #1 chk_reset_outputs();
    q.delete();
    starve = 0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1;
    repeat (3) begin
      step();
      chk("t6_no_write", {31'd0, last_we}, 32'd0);
    end
    chk("t6_rf13", dut_rf[13], 32'd0);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      wb_we    = ($urandom_range(0, 99) < 55);
      wb_reg   = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      md_valid = 1'($urandom_range(0, 1));
      md_reg   = 5'($urandom_range(0, 7));
      md_exc   = ($urandom_range(0, 15) == 0);
      md_data  = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
